// File: rtl/aes_spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_spi_slave_if
// Brief    : Serial link between SPI-style master and the AES slave front end.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_spi_slave_if;
  logic cs_n;
  logic mosi;
  logic mosi_valid;
  logic miso;
  logic miso_valid;

  modport master (output cs_n, output mosi, output mosi_valid,
                  input  miso, input  miso_valid);
  modport slave  (input  cs_n, input  mosi, input  mosi_valid,
                  output miso, output miso_valid);
endinterface
`default_nettype wire

// File: rtl/aes_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : aes_spi_slave
// Brief    : Receives a message+key frame serially, hands it to a cipher core,
//            and streams the core result back MSB first.
// Revision : 1.0 - initial release
// ============================================================================
module aes_spi_slave #(
  parameter int NK = 4,
  parameter int NB = 4
) (
  input  wire                 in_clk,
  input  wire                 rst,
  aes_spi_slave_if.slave      spi,
  output logic [32*NB-1:0]    core_msg_o,
  output logic [32*NK-1:0]    core_key_o,
  output logic                core_start_o,
  input  wire                 core_done_i,
  input  wire  [32*NB-1:0]    core_result_i,
  output logic                busy_o
);

  localparam int MW = 32 * NB;
  localparam int KW = 32 * NK;
  localparam int FW = MW + KW;
  localparam int CW = $clog2(FW + 1);

  localparam logic [CW-1:0] FRAME_LAST = CW'(FW - 1);
  localparam logic [CW-1:0] SEND_LAST  = CW'(MW);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_CORE = 2'd2,
    S_SEND = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // Holds all frame bits but the final one, which is taken straight from mosi.
  logic [FW-2:0]   shift_q, shift_d;
  // Top bit is already on miso; the remaining result bits follow.
  logic [MW-1:0]   tx_q, tx_d;
  logic [MW-1:0]   msg_q, msg_d;
  logic [KW-1:0]   key_q, key_d;
  logic            start_q, start_d;
  logic            miso_q, miso_d;
  logic            mval_q, mval_d;

  // Next-state and datapath decisions; cs_n high always wins over data/done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    msg_d   = msg_q;
    key_d   = key_q;
    start_d = 1'b0;
    miso_d  = 1'b0;
    mval_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!spi.cs_n && spi.mosi_valid) begin
          shift_d = {{(FW-2){1'b0}}, spi.mosi};
          cnt_d   = CW'(1);
          state_d = S_RECV;
        end
      end

      S_RECV: begin
        if (spi.cs_n) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (spi.mosi_valid) begin
          if (cnt_q == FRAME_LAST) begin
            {msg_d, key_d} = {shift_q, spi.mosi};
            start_d = 1'b1;
            shift_d = '0;
            cnt_d   = '0;
            state_d = S_CORE;
          end else begin
            shift_d = {shift_q[FW-3:0], spi.mosi};
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end

      S_CORE: begin
        if (spi.cs_n) begin
          state_d = S_IDLE;
        end else if (core_done_i) begin
          miso_d  = core_result_i[MW-1];
          mval_d  = 1'b1;
          tx_d    = {core_result_i[MW-2:0], 1'b0};
          cnt_d   = CW'(1);
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (spi.cs_n || (cnt_q == SEND_LAST)) begin
          tx_d    = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          miso_d  = tx_q[MW-1];
          mval_d  = 1'b1;
          tx_d    = {tx_q[MW-2:0], 1'b0};
          cnt_d   = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      tx_q    <= '0;
      msg_q   <= '0;
      key_q   <= '0;
      start_q <= 1'b0;
      miso_q  <= 1'b0;
      mval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      msg_q   <= msg_d;
      key_q   <= key_d;
      start_q <= start_d;
      miso_q  <= miso_d;
      mval_q  <= mval_d;
    end
  end

  assign spi.miso       = miso_q;
  assign spi.miso_valid = mval_q;
  assign core_msg_o     = msg_q;
  assign core_key_o     = key_q;
  assign core_start_o   = start_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_spi_slave
// Brief    : Self-checking bench for aes_spi_slave with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_spi_slave;
  localparam int MW = 128;
  localparam int KW = 128;
  localparam int FW = MW + KW;

  logic          in_clk = 1'b0;
  logic          rst;
  logic [MW-1:0] core_msg;
  logic [KW-1:0] core_key;
  logic          core_start;
  logic          core_done;
  logic [MW-1:0] core_result;
  logic          busy;

  aes_spi_slave_if spi ();

  aes_spi_slave #(.NK(4), .NB(4)) dut (
    .in_clk        (in_clk),
    .rst           (rst),
    .spi           (spi),
    .core_msg_o    (core_msg),
    .core_key_o    (core_key),
    .core_start_o  (core_start),
    .core_done_i   (core_done),
    .core_result_i (core_result),
    .busy_o        (busy)
  );

  always #5 in_clk = ~in_clk;

  int n_checks  = 0;
  int n_pass    = 0;
  int cyc       = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int valid_cnt = 0;
  int t0        = 0;

  // Reference model: the last frame the master completed.
  logic [MW-1:0] exp_msg = '0;
  logic [KW-1:0] exp_key = '0;

  always @(posedge in_clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  always @(negedge in_clk) begin
    if (core_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (spi.miso_valid) valid_cnt <= valid_cnt + 1;
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Sends the first nbits of fr MSB first, with an optional fixed gap and random gaps.
  task automatic drive_bits(input logic [FW-1:0] fr, input int nbits,
                            input int gap_at, input int gap_len, input int gap_prob);
    for (int i = 0; i < nbits; i++) begin
      if (i == gap_at) begin
        repeat (gap_len) begin
          @(negedge in_clk);
          spi.cs_n = 1'b0; spi.mosi_valid = 1'b0; spi.mosi = 1'($urandom);
        end
      end
      if (gap_prob > 0 && i > 0) begin
        while (int'($urandom_range(99)) < gap_prob) begin
          @(negedge in_clk);
          spi.cs_n = 1'b0; spi.mosi_valid = 1'b0; spi.mosi = 1'($urandom);
        end
      end
      @(negedge in_clk);
      spi.cs_n = 1'b0; spi.mosi = fr[FW-1-i]; spi.mosi_valid = 1'b1;
      if (i == 0) t0 = cyc;
    end
  endtask

  // Cipher-core stand-in: answers lat cycles after being called.
  task automatic core_reply(input logic [MW-1:0] res, input int lat);
    repeat (lat) @(negedge in_clk);
    core_done = 1'b1; core_result = res;
    @(negedge in_clk);
    core_done = 1'b0; core_result = rnd128();
  endtask

  // Gathers the contiguous miso_valid burst (bounded).
  task automatic collect(output logic [MW-1:0] got, output int n);
    got = '0; n = 0;
    for (int k = 0; k < 60; k++) begin
      if (spi.miso_valid) break;
      @(negedge in_clk);
    end
    while (spi.miso_valid && n < MW + 8) begin
      got = {got[MW-2:0], spi.miso};
      n++;
      @(negedge in_clk);
    end
  endtask

  // Sends a whole frame, ends at the cycle core_start should be visible.
  task automatic full_frame(input logic [MW-1:0] m, input logic [KW-1:0] k,
                            input int gap_at, input int gap_len, input int gap_prob);
    drive_bits({m, k}, FW, gap_at, gap_len, gap_prob);
    @(negedge in_clk);
    spi.mosi_valid = 1'b0;
    exp_msg = m; exp_key = k;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge in_clk);
    n_checks++; if (core_msg !== '0) $display("FAIL rst_msg got=%h exp=0", core_msg); else n_pass++;
    n_checks++; if (core_key !== '0) $display("FAIL rst_key got=%h exp=0", core_key); else n_pass++;
    n_checks++; if (core_start !== 1'b0) $display("FAIL rst_start got=%b exp=0", core_start); else n_pass++;
    n_checks++; if (spi.miso !== 1'b0) $display("FAIL rst_miso got=%b exp=0", spi.miso); else n_pass++;
    n_checks++; if (spi.miso_valid !== 1'b0) $display("FAIL rst_mval got=%b exp=0", spi.miso_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
    rst = 1'b0;
    @(negedge in_clk);
  endtask

  task automatic test_frame();
    logic [MW-1:0] res, got;
    int n, s0;
    res = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    s0 = start_cnt;
    full_frame(128'h00112233445566778899AABBCCDDEEFF, 128'h000102030405060708090A0B0C0D0E0F, -1, 0, 0);
    n_checks++; if (core_start !== 1'b1) $display("FAIL frame_start got=%b exp=1", core_start); else n_pass++;
    n_checks++; if (core_msg !== exp_msg) $display("FAIL frame_msg got=%h exp=%h", core_msg, exp_msg); else n_pass++;
    n_checks++; if (core_key !== exp_key) $display("FAIL frame_key got=%h exp=%h", core_key, exp_key); else n_pass++;
    #1;
    n_checks++; if (start_cyc - t0 !== 256) $display("FAIL frame_latency got=%0d exp=256", start_cyc - t0); else n_pass++;
    @(negedge in_clk);
    n_checks++; if (core_start !== 1'b0) $display("FAIL frame_pulse_width got=%b exp=0", core_start); else n_pass++;
    core_reply(res, 4);
    collect(got, n);
    n_checks++; if (n !== MW) $display("FAIL frame_nbits got=%0d exp=%0d", n, MW); else n_pass++;
    n_checks++; if (got !== res) $display("FAIL frame_miso got=%h exp=%h", got, res); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL frame_busy_end got=%b exp=0", busy); else n_pass++;
    n_checks++; if (start_cnt !== s0 + 1) $display("FAIL frame_start_count got=%0d exp=%0d", start_cnt, s0 + 1); else n_pass++;
  endtask

  task automatic test_gap();
    logic [MW-1:0] res, got;
    int n;
    res = rnd128();
    full_frame(rnd128(), rnd128(), 100, 3, 0);
    #1;
    n_checks++; if (start_cyc - t0 !== 259) $display("FAIL gap_latency got=%0d exp=259", start_cyc - t0); else n_pass++;
    n_checks++; if (core_msg !== exp_msg) $display("FAIL gap_msg got=%h exp=%h", core_msg, exp_msg); else n_pass++;
    n_checks++; if (core_key !== exp_key) $display("FAIL gap_key got=%h exp=%h", core_key, exp_key); else n_pass++;
    core_reply(res, int'($urandom_range(8)));
    collect(got, n);
    n_checks++; if (n !== MW || got !== res) $display("FAIL gap_miso got=%h/%0d exp=%h/%0d", got, n, res, MW); else n_pass++;
  endtask

  task automatic test_abort_recv();
    logic [MW-1:0] res, got;
    int n, s0;
    s0 = start_cnt;
    drive_bits({rnd128(), rnd128()}, 50, -1, 0, 0);
    @(negedge in_clk);
    spi.cs_n = 1'b1; spi.mosi_valid = 1'b1; spi.mosi = 1'b1;
    @(negedge in_clk);
    spi.mosi_valid = 1'b0; spi.cs_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (start_cnt !== s0) $display("FAIL abort_no_start got=%0d exp=%0d", start_cnt, s0); else n_pass++;
    n_checks++; if (core_msg !== exp_msg || core_key !== exp_key)
      $display("FAIL abort_hold got=%h_%h exp=%h_%h", core_msg, core_key, exp_msg, exp_key); else n_pass++;
    repeat (2) @(negedge in_clk);
    res = rnd128();
    full_frame(rnd128(), rnd128(), -1, 0, 10);
    n_checks++; if (core_start !== 1'b1) $display("FAIL abort_new_start got=%b exp=1", core_start); else n_pass++;
    n_checks++; if (core_msg !== exp_msg || core_key !== exp_key)
      $display("FAIL abort_new_frame got=%h_%h exp=%h_%h", core_msg, core_key, exp_msg, exp_key); else n_pass++;
    core_reply(res, 3);
    collect(got, n);
    n_checks++; if (n !== MW || got !== res) $display("FAIL abort_new_miso got=%h/%0d exp=%h/%0d", got, n, res, MW); else n_pass++;
  endtask

  task automatic test_rst_send();
    logic [MW-1:0] res;
    logic [39:0] got40;
    int v0;
    res = rnd128();
    got40 = '0;
    full_frame(rnd128(), rnd128(), -1, 0, 0);
    core_reply(res, 2);
    for (int k = 0; k < 60; k++) begin
      if (spi.miso_valid) break;
      @(negedge in_clk);
    end
    for (int b = 0; b < 40; b++) begin
      got40 = {got40[38:0], spi.miso};
      @(negedge in_clk);
    end
    n_checks++; if (got40 !== res[MW-1:MW-40]) $display("FAIL rsts_prefix got=%h exp=%h", got40, res[MW-1:MW-40]); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (spi.miso_valid !== 1'b0 || spi.miso !== 1'b0)
      $display("FAIL rsts_miso got=%b%b exp=00", spi.miso_valid, spi.miso); else n_pass++;
    n_checks++; if (busy !== 1'b0 || core_start !== 1'b0) $display("FAIL rsts_busy got=%b%b exp=00", busy, core_start); else n_pass++;
    n_checks++; if (core_msg !== '0 || core_key !== '0) $display("FAIL rsts_regs got=%h_%h exp=0", core_msg, core_key); else n_pass++;
    v0 = valid_cnt;
    @(negedge in_clk);
    rst = 1'b0;
    exp_msg = '0; exp_key = '0;
    repeat (10) @(negedge in_clk);
    #1;
    n_checks++; if (valid_cnt !== v0 || busy !== 1'b0)
      $display("FAIL rsts_quiet got=%0d/%b exp=%0d/0", valid_cnt, busy, v0); else n_pass++;
  endtask

  task automatic test_done_ignored();
    int v0;
    v0 = valid_cnt;
    @(negedge in_clk);
    core_done = 1'b1; core_result = rnd128();
    repeat (3) @(negedge in_clk);
    core_done = 1'b0;
    @(negedge in_clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_done_busy got=%b exp=0", busy); else n_pass++;
    full_frame(rnd128(), rnd128(), -1, 0, 0);
    n_checks++; if (core_msg !== exp_msg || core_key !== exp_key)
      $display("FAIL core_abort_frame got=%h_%h exp=%h_%h", core_msg, core_key, exp_msg, exp_key); else n_pass++;
    spi.cs_n = 1'b1; core_done = 1'b1; core_result = rnd128();
    @(negedge in_clk);
    core_done = 1'b0;
    n_checks++; if (busy !== 1'b0 || spi.miso_valid !== 1'b0)
      $display("FAIL core_abort_state got=%b%b exp=00", busy, spi.miso_valid); else n_pass++;
    repeat (6) @(negedge in_clk);
    spi.cs_n = 1'b0;
    #1;
    n_checks++; if (valid_cnt !== v0) $display("FAIL done_no_send got=%0d exp=%0d", valid_cnt, v0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [MW-1:0] res, got;
    int n;
    for (int it = 0; it < 4; it++) begin
      res = rnd128();
      full_frame(rnd128(), rnd128(), -1, 0, 15);
      n_checks++; if (core_start !== 1'b1 || core_msg !== exp_msg || core_key !== exp_key)
        $display("FAIL b2b_frame%0d got=%b %h_%h exp=1 %h_%h", it, core_start, core_msg, core_key, exp_msg, exp_key);
      else n_pass++;
      core_reply(res, int'($urandom_range(10)));
      collect(got, n);
      n_checks++; if (n !== MW || got !== res) $display("FAIL b2b_miso%0d got=%h/%0d exp=%h/%0d", it, got, n, res, MW); else n_pass++;
    end
  endtask

  initial begin
    spi.cs_n = 1'b1; spi.mosi = 1'b0; spi.mosi_valid = 1'b0;
    core_done = 1'b0; core_result = '0; rst = 1'b1;
    test_reset();
    test_frame();
    test_gap();
    test_abort_recv();
    test_rst_send();
    test_done_ignored();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/aes_spi_slave.md
AES_SPI_SLAVE -- requirements
Module: aes_spi_slave

Interface
REQ-001 SHALL have parameter NK, default 4, key length in 32-bit words.
REQ-002 SHALL have parameter NB, default 4, block length in 32-bit words; message width MW=32*NB, key width KW=32*NK.
REQ-003 in_clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cs_n  input  1  chip select from master, active-low.
REQ-006 mosi  input  1  serial data from master.
REQ-007 mosi_valid  input  1  qualifies mosi for the current cycle.
REQ-008 miso  output  1  serial result to master.
REQ-009 miso_valid  output  1  qualifies miso; master samples miso when high.
REQ-010 core_msg  output  MW  received message, to the cipher core.
REQ-011 core_key  output  KW  received key, to the cipher core.
REQ-012 core_start  output  1  one-cycle request to the cipher core.
REQ-013 core_done  input  1  cipher core result-ready pulse.
REQ-014 core_result  input  MW  cipher core output; valid in the cycle core_done is high.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, RECV, CORE, SEND.
REQ-017 IDLE: when cs_n=0 and mosi_valid=1, capture mosi as bit MW+KW-1 and go to RECV with receive count 1.
REQ-018 RECV: each cycle with cs_n=0 and mosi_valid=1, shift mosi in MSB-first and increment the count; a cycle with mosi_valid=0 holds the register and count.
REQ-019 Frame SHALL be MW+KW bits: the first MW bits form core_msg and the last KW bits form core_key, each MSB first.
REQ-020 When the count reaches MW+KW, update core_msg/core_key in the same edge, pulse core_start high for exactly the next cycle, and enter CORE.
REQ-021 core_msg/core_key SHALL change only at frame completion and hold otherwise.
REQ-022 CORE: wait indefinitely for core_done=1; latch core_result into the transmit register and enter SEND on that edge.
REQ-023 SEND: for MW consecutive cycles, drive miso with result bits MW-1 down to 0 and drive miso_valid=1; both are registered outputs.
REQ-024 After the last bit, miso_valid=0 and miso=0 on the next edge, and the state returns to IDLE.
REQ-025 Outside SEND, miso=0 and miso_valid=0.
REQ-026 cs_n=1 in RECV SHALL abort: discard partial bits, reset the count, go to IDLE, and leave core_msg/core_key unchanged.
REQ-027 cs_n=1 in CORE or SEND SHALL abort to IDLE, force miso_valid=0, and discard any pending result.
REQ-028 cs_n=1 and core_done=1 in the same CORE cycle: the abort wins and the result is dropped.
REQ-029 core_done SHALL be ignored in IDLE, RECV and SEND.
REQ-030 In RECV, mosi_valid=1 with cs_n=1: the abort takes priority.
REQ-031 Counters SHALL be sized ceil(log2(MW+KW+1)) bits and SHALL NOT wrap within a frame.

Reset
REQ-032 On rst=1, the state SHALL be IDLE, with all of the following cleared:
- counters
- shift and transmit registers
- core_msg and core_key
- core_start, miso, miso_valid and busy
REQ-033 rst asserted mid-frame, mid-CORE or mid-SEND SHALL take effect immediately; no partial output follows its release.
REQ-034 After rst is released, the first qualified bit SHALL be treated as the start of a new frame.

Verification
REQ-035 Frame: msg=128'h00112233445566778899AABBCCDDEEFF and key=128'h000102030405060708090A0B0C0D0E0F, sent in 256 valid cycles -> core_msg/core_key equal these values and core_start pulses once, one cycle after the 256th bit.
REQ-036 Core returns core_result=128'h69C4E0D86A7B0430D8CDB78070B4C55A, core_done 5 cycles after start -> 128 consecutive cycles of miso_valid=1, with the miso sequence MSB first equal to that value, then miso_valid=0 and busy=0.
REQ-037 mosi_valid gapped low for 3 cycles at bit 100 -> the frame is still captured correctly and core_start is delayed by 3 cycles.
REQ-038 cs_n raised after 50 bits, then a full new frame is sent -> no core_start for the aborted frame, and the new frame is captured intact.
REQ-039 rst pulsed during SEND at bit 40 -> miso_valid=0 immediately, and all outputs return to their reset values.
REQ-040 core_done asserted in IDLE, and cs_n=1 coincident with core_done in CORE -> no SEND occurs and miso_valid stays 0.
